pixel_scan_controller: RTL

PIXEL_SCAN_CONTROLLER -- requirements
Module: pixel_scan_controller

---
 rtl/pixel_scan_controller.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/pixel_scan_controller.sv
// Raster scan controller: on start, walks a IMG_W x IMG_H frame in row-major
// order, issuing one pixel strobe every DIV clocks (held off by stall), with
// column/row/linear-address outputs and sof/eol/eof framing flags.
//
// Ports:
//   clk     in   rising-edge clock
//   RESET   in   asynchronous active-low reset
//   start   in   frame request, sampled only while idle
//   stall   in   downstream hold; defers the pending pixel strobe
//   pix_en  out  one-cycle pixel strobe
//   col     out  column of strobed pixel   [COL_W]
//   row     out  row of strobed pixel      [ROW_W]
//   addr    out  linear pixel address      [ADDR_W]
//   sof     out  first pixel of frame (with pix_en)
//   eol     out  last pixel of line (with pix_en)
//   eof     out  last pixel of frame (with pix_en)
//   busy    out  frame in progress
//   done    out  one-cycle frame completion pulse
module pixel_scan_controller #(
   parameter int unsigned IMG_W  = 256,
   parameter int unsigned IMG_H  = 256,
   parameter int unsigned DIV    = 3,
   parameter int unsigned COL_W  = 8,
   parameter int unsigned ROW_W  = 8,
   parameter int unsigned ADDR_W = 16
) (
   input  logic              clk,
   input  logic              RESET,
   input  logic              start,
   input  logic              stall,
   output logic              pix_en,
   output logic [COL_W-1:0]  col,
   output logic [ROW_W-1:0]  row,
   output logic [ADDR_W-1:0] addr,
   output logic              sof,
   output logic              eol,
   output logic              eof,
   output logic              busy,
   output logic              done
);

   localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t              state, state_nx;
   logic [DIV_W-1:0]    div_cnt, div_cnt_nx;
   // coordinate of the next pixel to be strobed
   logic [COL_W-1:0]    ncol, ncol_nx;
   logic [ROW_W-1:0]    nrow, nrow_nx;
   logic [ADDR_W-1:0]   naddr, naddr_nx;
   logic [COL_W-1:0]    col_nx;
   logic [ROW_W-1:0]    row_nx;
   logic [ADDR_W-1:0]   addr_nx;
   logic                pix_en_nx, sof_nx, eol_nx, eof_nx, busy_nx, done_nx;
   logic                last_col, last_row, div_wrap;

   assign last_col = (ncol == COL_W'(IMG_W - 1));
   assign last_row = (nrow == ROW_W'(IMG_H - 1));
   assign div_wrap = (div_cnt == DIV_W'(DIV - 1));

   // Next-state and next-output logic
   always_comb begin
      state_nx   = state;
      div_cnt_nx = div_cnt;
      ncol_nx    = ncol;
      nrow_nx    = nrow;
      naddr_nx   = naddr;
      col_nx     = col;
      row_nx     = row;
      addr_nx    = addr;
      pix_en_nx  = 1'b0;
      sof_nx     = 1'b0;
      eol_nx     = 1'b0;
      eof_nx     = 1'b0;
      busy_nx    = busy;
      done_nx    = 1'b0;

      case (state)
         IDLE: begin
            if (start) begin
               state_nx   = SCAN;
               busy_nx    = 1'b1;
               div_cnt_nx = '0;
               ncol_nx    = '0;
               nrow_nx    = '0;
               naddr_nx   = '0;
            end
         end
         SCAN: begin
            if (!div_wrap) begin
               div_cnt_nx = div_cnt + DIV_W'(1);
            end else if (!stall) begin
               // stall only matters once the strobe is due; div_cnt holds meanwhile
               pix_en_nx  = 1'b1;
               col_nx     = ncol;
               row_nx     = nrow;
               addr_nx    = naddr;
               sof_nx     = (naddr == '0);
               eol_nx     = last_col;
               eof_nx     = last_col && last_row;
               div_cnt_nx = '0;
               naddr_nx   = naddr + ADDR_W'(1);
               if (last_col) begin
                  ncol_nx = '0;
                  nrow_nx = nrow + ROW_W'(1);
               end else begin
                  ncol_nx = ncol + COL_W'(1);
               end
               if (last_col && last_row) begin
                  state_nx = DONE;
               end
            end
         end
         DONE: begin
            done_nx  = 1'b1;
            busy_nx  = 1'b0;
            state_nx = IDLE;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge clk or negedge RESET) begin
      if (!RESET) begin
         state   <= IDLE;
         div_cnt <= '0;
         ncol    <= '0;
         nrow    <= '0;
         naddr   <= '0;
         col     <= '0;
         row     <= '0;
         addr    <= '0;
         pix_en  <= 1'b0;
         sof     <= 1'b0;
         eol     <= 1'b0;
         eof     <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         state   <= state_nx;
         div_cnt <= div_cnt_nx;
         ncol    <= ncol_nx;
         nrow    <= nrow_nx;
         naddr   <= naddr_nx;
         col     <= col_nx;
         row     <= row_nx;
         addr    <= addr_nx;
         pix_en  <= pix_en_nx;
         sof     <= sof_nx;
         eol     <= eol_nx;
         eof     <= eof_nx;
         busy    <= busy_nx;
         done    <= done_nx;
      end
   end

endmodule
